oserdes_error_monitor: RTL and testbench
========================================

Name: oserdes_error_monitor

Overview:
- Multi-channel status collector for the OSERDES rate test harness.
- Takes one error strobe from each oserdes_test channel. All channels run in the fabric clock domain.
- Masks a warm-up window after reset or clear, then keeps a sticky flag and a saturating error count per channel.
- Periodically streams one report word per channel over a valid/ready interface for a UART or ILA sink. Generalises the fixed 10-channel LED-only status logic to N channels with counting and reporting.

Parameters:
- N_CH, 10, number of monitored channels (1..64).
- CNT_W, 16, width of each per-channel error counter.
- WARMUP_CYCLES, 1024, cycles after reset or clear during which err_in is ignored (>=1).
- REPORT_PERIOD, 2**20, idle cycles between end of one report scan and start of the next (>=2).
- HB_BIT, 23, heartbeat counter bit driven to the hb output.

Ports:
- clk  in  1  fabric clock.
- RST  in  1  reset; synchronous, active-high; clock clk.
- clr  in  1  single-cycle pulse: clear counters and sticky flags, restart warm-up.
- err_in  in  N_CH  per-channel error strobe, synchronous to clk, level sampled every cycle.
- armed  out  1  high once the warm-up window has elapsed.
- err_sticky  out  N_CH  per-channel sticky error flag.
- ok_n  out  N_CH  active-low pass indication (= ~err_sticky & {N_CH{armed}}), driven straight to LEDs.
- hb  out  1  heartbeat bit.
- rpt_valid  out  1  report word valid.
- rpt_ready  in  1  sink accepts word.
- rpt_data  out  8+CNT_W  {channel index [7:0], error count [CNT_W-1:0]}.
- rpt_last  out  1  high on the word for channel N_CH-1.

Behaviour:
- Reset values (RST high at edge): armed=0, err_sticky=0, all counters=0, rpt_valid=0, rpt_last=0, rpt_data=0, warm-up counter=0, period timer=0, heartbeat counter=0, FSM=IDLE.
- Warm-up:
  - Counter increments from 0 after RST or clr.
  - armed is registered high on the cycle after the counter reaches WARMUP_CYCLES-1.
  - While armed=0, err_in has no effect.
- Counting (armed=1): err_in[k]=1 in a cycle sets err_sticky[k] and increments cnt[k] on that edge.
  - cnt saturates at 2**CNT_W-1 and never wraps.
  - err_sticky is visible the cycle after the strobe.
- clr:
  - At the next edge, zeroes all counters and sticky flags and drops armed to 0.
  - clr has priority over a simultaneous err_in.
- Report FSM:
  - IDLE: period timer counts. At REPORT_PERIOD-1, set ch=0 and go to LOAD.
  - LOAD: capture {ch, cnt[ch]} into rpt_data, set rpt_last=(ch==N_CH-1), assert rpt_valid. Go to SEND.
  - SEND: hold rpt_data, rpt_last and rpt_valid stable until rpt_valid&&rpt_ready.
    - On a handshake with last: deassert valid, clear timer, go to IDLE.
    - On a handshake otherwise: ch++ and go to LOAD.
    - Throughput is one word per 2 cycles when ready is constantly high.
  - Captured word: the count is sampled at LOAD. Later increments or clr do not alter a word already presented; subsequent words reflect updated values.
  - Reports run regardless of armed.
  - Channel index is zero-extended to 8 bits.
- RST mid-scan: valid drops at that edge and the scan is abandoned. There is no partial-word protocol obligation.
- Heartbeat: free-running 25-bit counter; hb = counter[HB_BIT].

Decomposition:
- Shared package oserdes_test_pkg holds:
  - report-word field constants (RPT_IDX_W=8, field offsets);
  - FSM state encoding (IDLE, LOAD, SEND);
  - the saturating-increment helper function.
- One natural sub-module: err_channel. Holds one channel's sticky flag and saturating counter with clr/armed gating, generated N_CH times.
- The FSM, warm-up, timer and heartbeat stay in the parent.

Test Plan:
1. Reset then err_in=all-ones during first 1023 cycles (WARMUP_CYCLES=1024) -> err_sticky=0, all counts 0, armed rises at cycle 1024, ok_n=0 before then.
2. Armed, pulse err_in[3] for 5 single cycles -> err_sticky=0x008, next report word for ch 3 = {8'h03,16'd5}, all other counts 0, ok_n[3]=0, others 1.
3. CNT_W=4, err_in[0] held high 40 cycles -> count saturates at 15, report word {8'h00,4'hF}.
4. rpt_ready low 50 cycles during SEND of ch 2, with err_in[2] pulsing meanwhile:
   - rpt_data stays constant and rpt_valid stays high;
   - after ready rises, exactly 10 words ch 0..9 are seen in order, with rpt_last only on ch 9.
5. clr coincident with err_in[1]=1 -> count[1]=0, sticky=0, armed=0 next cycle, warm-up restarts for 1024 cycles.
6. RST asserted while rpt_valid=1 on ch 4 -> rpt_valid=0 next cycle, no further words until REPORT_PERIOD elapses, next scan starts at ch 0.

Source files
------------

// File: rtl/oserdes_test_pkg.sv
// Shared definitions for the OSERDES rate-test status logic.
//   - report-word field layout: {channel index [RPT_IDX_W-1:0], count [CNT_W-1:0]}
//   - report FSM state encoding
//   - saturating increment helper used by the per-channel counters
package oserdes_test_pkg;

  // Report word layout. The count occupies the low bits starting at
  // RPT_CNT_LSB. The channel index sits directly above it, starting at CNT_W.
  localparam int unsigned RPT_IDX_W   = 8;
  localparam int unsigned RPT_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } rpt_state_t;

  // Counters up to SAT_W bits wide are handled by the helper.
  localparam int unsigned SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/oserdes_error_monitor_err_channel.sv
// One monitored channel: a sticky error flag and a saturating error counter.
// Ports:
//   clk, RST  - fabric clock and synchronous active-high reset
//   clr       - clears flag and counter; has priority over err
//   armed     - err is ignored while low (warm-up window)
//   err       - error strobe, sampled every cycle
//   sticky    - set by the first counted error, held until RST/clr
//   cnt       - error count, saturates at 2**CNT_W-1
module err_channel
  import oserdes_test_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             armed,
  input  logic             err,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((64'd1 << CNT_W) - 64'd1);

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (armed && err) begin
      sticky <= 1'b1;
      cnt    <= CNT_W'(sat_inc(SAT_W'(cnt), CNT_MAX));
    end
  end

endmodule

// File: rtl/oserdes_error_monitor.sv
// Multi-channel status collector for the OSERDES rate test harness.
// Masks a warm-up window after RST/clr, keeps per-channel sticky flags and
// saturating counts, and periodically streams one report word per channel.
// Ports:
//   clk, RST    - fabric clock, synchronous active-high reset
//   clr         - pulse: clear counts/flags, restart warm-up
//   err_in      - per-channel error strobes
//   armed       - warm-up window has elapsed
//   err_sticky  - per-channel sticky error flags
//   ok_n        - LED drive, ~err_sticky gated by armed
//   hb          - heartbeat (bit HB_BIT of a free-running 25-bit counter)
//   rpt_valid, rpt_ready, rpt_data, rpt_last - report stream,
//                 rpt_data = {channel index [7:0], count [CNT_W-1:0]}
module oserdes_error_monitor
  import oserdes_test_pkg::*;
#(
  parameter int unsigned N_CH          = 10,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WARMUP_CYCLES = 1024,
  parameter int unsigned REPORT_PERIOD = 2**20,
  parameter int unsigned HB_BIT        = 23
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      clr,
  input  logic [N_CH-1:0]           err_in,
  output logic                      armed,
  output logic [N_CH-1:0]           err_sticky,
  output logic [N_CH-1:0]           ok_n,
  output logic                      hb,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [RPT_IDX_W+CNT_W-1:0] rpt_data,
  output logic                      rpt_last
);

  localparam int unsigned WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned TMR_W = $clog2(REPORT_PERIOD);
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned HB_W  = 25;

  // ---------------- warm-up ----------------
  logic [WU_W-1:0] wu_cnt;

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      wu_cnt <= '0;
      armed  <= 1'b0;
    end else if (!armed) begin
      if (wu_cnt == WU_W'(WARMUP_CYCLES - 1))
        armed <= 1'b1;
      else
        wu_cnt <= wu_cnt + 1'b1;
    end
  end

  // ---------------- channels ----------------
  logic [CNT_W-1:0] cnt_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    err_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .RST    (RST),
      .clr    (clr),
      .armed  (armed),
      .err    (err_in[k]),
      .sticky (err_sticky[k]),
      .cnt    (cnt_arr[k])
    );
  end

  always_comb ok_n = ~err_sticky & {N_CH{armed}};

  // ---------------- heartbeat ----------------
  logic [HB_W-1:0] hb_cnt;

  always_ff @(posedge clk) begin
    if (RST) hb_cnt <= '0;
    else     hb_cnt <= hb_cnt + 1'b1;
  end

  always_comb hb = hb_cnt[HB_BIT];

  // ---------------- report FSM ----------------
  rpt_state_t       state, state_d;
  logic [TMR_W-1:0] tmr;
  logic [CH_W-1:0]  ch;
  logic             tmr_done;
  logic             ch_last;
  logic             hs;

  always_comb begin
    tmr_done = (tmr == TMR_W'(REPORT_PERIOD - 1));
    ch_last  = (ch == CH_W'(N_CH - 1));
    hs       = rpt_valid && rpt_ready;
  end

  always_ff @(posedge clk) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (tmr_done) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (hs) state_d = rpt_last ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // The word is captured in LOAD and only touched again at the next LOAD,
  // so later increments or clr cannot disturb a word being presented.
  always_ff @(posedge clk) begin
    if (RST) begin
      tmr       <= '0;
      ch        <= '0;
      rpt_valid <= 1'b0;
      rpt_last  <= 1'b0;
      rpt_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tmr_done) begin
            tmr <= '0;
            ch  <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_LOAD: begin
          rpt_data  <= {RPT_IDX_W'(ch), cnt_arr[ch]};
          rpt_last  <= ch_last;
          rpt_valid <= 1'b1;
        end
        ST_SEND: begin
          if (hs) begin
            rpt_valid <= 1'b0;
            if (rpt_last) begin
              rpt_last <= 1'b0;
              tmr      <= '0;
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oserdes_error_monitor.sv
module tb_oserdes_error_monitor;

  localparam int unsigned N_CH = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WU = 1024;
  localparam int unsigned RP = 300;
  localparam int unsigned HBB = 3;
  localparam int unsigned DW = 8 + CNT_W;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            RST = 1'b1;
  logic            clr = 1'b0;
  logic [N_CH-1:0] err_in = '0;
  logic            rpt_ready = 1'b1;
  logic            armed;
  logic [N_CH-1:0] err_sticky;
  logic [N_CH-1:0] ok_n;
  logic            hb;
  logic            rpt_valid;
  logic [DW-1:0]   rpt_data;
  logic            rpt_last;

  oserdes_error_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WARMUP_CYCLES(WU), .REPORT_PERIOD(RP), .HB_BIT(HBB)
  ) dut (
    .clk(clk), .RST(RST), .clr(clr), .err_in(err_in),
    .armed(armed), .err_sticky(err_sticky), .ok_n(ok_n), .hb(hb),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data), .rpt_last(rpt_last)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } word_t;

  word_t       q[$];
  int unsigned last_seen = 0;

  // Record every accepted word; sampled mid-cycle, the handshake completes at the next edge.
  always @(negedge clk) begin
    if (!RST && rpt_valid && rpt_ready) begin
      word_t w;
      w.idx  = rpt_data[DW-1:CNT_W];
      w.cnt  = rpt_data[CNT_W-1:0];
      w.last = rpt_last;
      q.push_back(w);
      if (rpt_last) last_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for n words starting at channel first_ch and compare against exp.
  task automatic collect(input string tag, input int unsigned exp[N_CH],
                         input int unsigned first_ch, input int unsigned n);
    int k = 0;
    while (q.size() < n && k < BUDGET) begin tick; k++; end
    chk({tag, " word count"}, 64'(q.size()), 64'(n));
    if (q.size() >= n) begin
      for (int unsigned i = 0; i < n; i++) begin
        int unsigned c = first_ch + i;
        chk($sformatf("%s ch%0d word", tag, c),
            {q[i].idx, q[i].cnt, q[i].last},
            {8'(c), CNT_W'(exp[c]), c == N_CH - 1});
      end
    end
  endtask

  // Skip to the end of the scan in progress (or the next one), then check a full scan.
  task automatic sync_scan(input string tag, input int unsigned exp[N_CH]);
    int unsigned start = last_seen;
    int k = 0;
    while (last_seen == start && k < BUDGET) begin tick; k++; end
    chk({tag, " scan end seen"}, 64'(last_seen != start), 64'd1);
    q.delete();
    collect(tag, exp, 0, N_CH);
  endtask

  initial begin
    int unsigned e[N_CH];
    int n;
    int nz;
    logic [DW-1:0] held;
    logic stable;

    e = '{default: 0};

    // ---- reset ----
    repeat (3) tick;
    chk("rst armed", armed, 0);
    chk("rst sticky", err_sticky, 0);
    chk("rst valid", rpt_valid, 0);
    chk("rst last", rpt_last, 0);
    chk("rst data", rpt_data, 0);
    chk("rst hb", hb, 0);

    // ---- 1: warm-up masks errors ----
    RST = 1'b0;
    err_in = '1;
    for (int t = 1; t <= 1023; t++) begin
      tick;
      if (t == 7) chk("hb t7", hb, 0);
      if (t == 8) chk("hb t8", hb, 1);
    end
    chk("wu armed 1023", armed, 0);
    chk("wu sticky", err_sticky, 0);
    chk("wu ok_n", ok_n, 0);
    err_in = '0;
    tick;
    chk("wu armed 1024", armed, 1);
    chk("wu sticky after", err_sticky, 0);
    chk("wu ok_n after", ok_n, 10'h3FF);
    nz = 0;
    foreach (q[i]) if (q[i].cnt != 0) nz++;
    chk("wu scans seen", 64'(q.size() >= N_CH), 1);
    chk("wu nonzero counts", 64'(nz), 0);

    // ---- 2: five pulses on ch3 ----
    for (int p = 0; p < 5; p++) begin
      err_in = 10'h008;
      tick;
      if (p == 0) chk("t2 sticky next cycle", err_sticky, 10'h008);
      err_in = '0;
      tick;
    end
    chk("t2 sticky", err_sticky, 10'h008);
    chk("t2 ok_n", ok_n, 10'h3F7);
    e[3] = 5;
    sync_scan("t2", e);

    // ---- 3: ch0 held 40 cycles saturates at 15 ----
    err_in = 10'h001;
    repeat (40) tick;
    err_in = '0;
    tick;
    chk("t3 sticky", err_sticky, 10'h009);
    e[0] = 15;
    sync_scan("t3", e);

    // ---- 4: stall on ch2 while ch2 keeps counting ----
    n = 0;
    while (!(rpt_valid && rpt_data[DW-1:CNT_W] == 8'd2) && n < BUDGET) begin tick; n++; end
    chk("t4 ch2 presented", 64'(rpt_valid && rpt_data[DW-1:CNT_W] == 8'd2), 1);
    rpt_ready = 1'b0;
    q.delete();
    held = rpt_data;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      err_in = (i < 14 && (i % 2) == 0) ? 10'h004 : 10'h000;
      tick;
      if (!rpt_valid || rpt_data !== held) stable = 1'b0;
    end
    err_in = '0;
    chk("t4 held stable", stable, 1);
    chk("t4 held word", held, 12'h020);
    rpt_ready = 1'b1;
    collect("t4 rest", e, 2, 8);
    q.delete();
    e[2] = 7;
    collect("t4 next", e, 0, N_CH);
    repeat (20) tick;
    chk("t4 no extra words", 64'(q.size()), 64'(N_CH));

    // ---- 5: clr beats a coincident error ----
    clr = 1'b1;
    err_in = 10'h002;
    tick;
    clr = 1'b0;
    err_in = '0;
    chk("t5 armed", armed, 0);
    chk("t5 sticky", err_sticky, 0);
    chk("t5 ok_n", ok_n, 0);
    err_in = 10'h002;
    repeat (1022) tick;
    err_in = '0;
    tick;
    chk("t5 armed 1023", armed, 0);
    tick;
    chk("t5 armed 1024", armed, 1);
    chk("t5 sticky after", err_sticky, 0);
    e = '{default: 0};
    sync_scan("t5", e);

    // ---- 6: RST mid-scan on ch4 ----
    n = 0;
    while (!(rpt_valid && rpt_data[DW-1:CNT_W] == 8'd4) && n < BUDGET) begin tick; n++; end
    chk("t6 ch4 presented", 64'(rpt_valid && rpt_data[DW-1:CNT_W] == 8'd4), 1);
    RST = 1'b1;
    tick;
    chk("t6 valid dropped", rpt_valid, 0);
    chk("t6 data cleared", rpt_data, 0);
    RST = 1'b0;
    q.delete();
    repeat (RP) tick;
    chk("t6 quiet valid", rpt_valid, 0);
    chk("t6 quiet words", 64'(q.size()), 0);
    tick;
    chk("t6 restart valid", rpt_valid, 1);
    chk("t6 restart word", rpt_data, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
